// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared widths, source encodings and lane merge helper
package wb_regfile_pkg;
    localparam int NUM_REGS   = 16;
    localparam int DATA_W     = 32;
    localparam int LANE_W     = 8;
    localparam int REG_IDX_W  = 4;
    localparam int LANES      = DATA_W / LANE_W;
    localparam int LANE_IDX_W = $clog2(LANES);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_sel_e;

    function automatic logic [DATA_W-1:0] merge_lane(
        input logic [DATA_W-1:0]     word,
        input logic [LANE_W-1:0]     lane_data,
        input logic [LANE_IDX_W-1:0] lane
    );
        logic [DATA_W-1:0] res;
        res = word;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LANE_IDX_W'(i)) res[i*LANE_W +: LANE_W] = lane_data;
        end
        return res;
    endfunction
endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB writeback inputs and decode-side read ports
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic [DATA_W-1:0]     Do;
    logic [LANE_W-1:0]     Dob;
    logic [DATA_W-1:0]     ALU_Result;
    logic [REG_IDX_W-1:0]  Rg;
    logic                  WE_C;
    logic                  WE_V;
    logic                  SEL_C;
    logic                  SEL_DAT;
    logic                  PROHIB_WB;
    logic [REG_IDX_W-1:0]  rs_a;
    logic [REG_IDX_W-1:0]  rs_b;
    logic [REG_IDX_W-1:0]  rv_a;
    logic [REG_IDX_W-1:0]  rv_b;
    logic [DATA_W-1:0]     rd_sa;
    logic [DATA_W-1:0]     rd_sb;
    logic [DATA_W-1:0]     rd_va;
    logic [DATA_W-1:0]     rd_vb;
    logic                  wb_commit;
    logic [LANE_IDX_W-1:0] lane_ptr_dbg;

    modport master (
        output Do, Dob, ALU_Result, Rg, WE_C, WE_V, SEL_C, SEL_DAT, PROHIB_WB,
               rs_a, rs_b, rv_a, rv_b,
        input  rd_sa, rd_sb, rd_va, rd_vb, wb_commit, lane_ptr_dbg
    );

    modport slave (
        input  Do, Dob, ALU_Result, Rg, WE_C, WE_V, SEL_C, SEL_DAT, PROHIB_WB,
               rs_a, rs_b, rv_a, rv_b,
        output rd_sa, rd_sb, rd_va, rd_vb, wb_commit, lane_ptr_dbg
    );
endinterface

// File: rtl/wb_regfile_vec_lane_packer.sv
// rtl/wb_regfile_vec_lane_packer.sv - per-register lane pointers and byte merge for vector writes
module vec_lane_packer
    import wb_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_IDX_W-1:0]  rg,
    input  logic                  wev,
    input  src_sel_e              src,
    input  logic [DATA_W-1:0]     cur_word,
    input  logic [LANE_W-1:0]     lane_data,
    input  logic [DATA_W-1:0]     word_data,
    output logic [DATA_W-1:0]     new_word,
    output logic [LANE_IDX_W-1:0] ptr
);
    logic [LANE_IDX_W-1:0] ptr_q [NUM_REGS];
    logic [LANE_IDX_W-1:0] ptr_next;

    assign ptr = ptr_q[rg];

    // A full-word write realigns packing to lane 0; the 2-bit increment wraps 3 -> 0.
    always_comb begin
        new_word = word_data;
        ptr_next = '0;
        if (src == SRC_MEM) begin
            new_word = merge_lane(cur_word, lane_data, ptr);
            ptr_next = ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) ptr_q[i] <= '0;
        end else if (wev) begin
            ptr_q[rg] <= ptr_next;
        end
    end
endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage: scalar/vector register files with bypassed reads
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    logic              wec;
    logic              wev;
    src_sel_e          src;
    logic [DATA_W-1:0] s_val;
    logic [DATA_W-1:0] v_new;
    logic [DATA_W-1:0] s_q [NUM_REGS];
    logic [DATA_W-1:0] v_q [NUM_REGS];
    logic              commit_q;

    assign src = src_sel_e'(bus.SEL_DAT);
    assign wec = bus.WE_C & ~bus.PROHIB_WB;
    assign wev = bus.WE_V & ~bus.PROHIB_WB;

    always_comb begin
        s_val = bus.ALU_Result;
        if (src == SRC_MEM) begin
            s_val = bus.SEL_C ? {{(DATA_W-LANE_W){1'b0}}, bus.Dob} : bus.Do;
        end
    end

    vec_lane_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .rg        (bus.Rg),
        .wev       (wev),
        .src       (src),
        .cur_word  (v_q[bus.Rg]),
        .lane_data (bus.Dob),
        .word_data (bus.ALU_Result),
        .new_word  (v_new),
        .ptr       (bus.lane_ptr_dbg)
    );

    // Bypass hands decode the post-write value; index 0 stays zero regardless.
    always_comb begin
        bus.rd_sa = s_q[bus.rs_a];
        if (wec && bus.rs_a == bus.Rg) bus.rd_sa = s_val;
        if (bus.rs_a == '0) bus.rd_sa = '0;
        bus.rd_sb = s_q[bus.rs_b];
        if (wec && bus.rs_b == bus.Rg) bus.rd_sb = s_val;
        if (bus.rs_b == '0) bus.rd_sb = '0;
        bus.rd_va = v_q[bus.rv_a];
        if (wev && bus.rv_a == bus.Rg) bus.rd_va = v_new;
        bus.rd_vb = v_q[bus.rv_b];
        if (wev && bus.rv_b == bus.Rg) bus.rd_vb = v_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                s_q[i] <= '0;
                v_q[i] <= '0;
            end
            commit_q <= 1'b0;
        end else begin
            if (wec && bus.Rg != '0) s_q[bus.Rg] <= s_val;
            if (wev) v_q[bus.Rg] <= v_new;
            commit_q <= wec | wev;
        end
    end

    assign bus.wb_commit = commit_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile against an architectural model
module tb_wb_regfile;
    typedef struct {
        int          id;
        bit          chk_rd;
        logic [31:0] sa;
        logic [31:0] sb;
        logic [31:0] va;
        logic [31:0] vb;
        logic [1:0]  ptr;
        logic        commit;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          failures = 0;
    int          step_no = 0;
    logic [31:0] sm [16];
    logic [31:0] vm [16];
    int          pm [16];
    logic        commit_m;

    wb_regfile_if bus();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, id, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk_rd) begin
                check("rd_sa", e.id, bus.rd_sa, e.sa);
                check("rd_sb", e.id, bus.rd_sb, e.sb);
                check("rd_va", e.id, bus.rd_va, e.va);
                check("rd_vb", e.id, bus.rd_vb, e.vb);
            end
            check("lane_ptr_dbg", e.id, {30'b0, bus.lane_ptr_dbg}, {30'b0, e.ptr});
            check("wb_commit", e.id, {31'b0, bus.wb_commit}, {31'b0, e.commit});
        end
    end

    task automatic step(input bit r, input logic [31:0] d, input logic [7:0] db, input logic [31:0] alu,
                        input int rg, input bit wc, input bit wv, input bit sc, input bit sd, input bit k,
                        input int ra, input int rb, input int va, input int vb);
        exp_t        x;
        logic [31:0] ns [16];
        logic [31:0] nv [16];
        int          np [16];
        logic [31:0] sval;
        bit          we_s, we_v;
        int          p;
        rst = r;
        bus.Do = d; bus.Dob = db; bus.ALU_Result = alu; bus.Rg = 4'(rg);
        bus.WE_C = wc; bus.WE_V = wv; bus.SEL_C = sc; bus.SEL_DAT = sd; bus.PROHIB_WB = k;
        bus.rs_a = 4'(ra); bus.rs_b = 4'(rb); bus.rv_a = 4'(va); bus.rv_b = 4'(vb);
        we_s = wc && !k;
        we_v = wv && !k;
        sval = !sd ? alu : (sc ? {24'h0, db} : d);
        ns = sm; nv = vm; np = pm;
        if (we_s && rg != 0) ns[rg] = sval;
        if (we_v) begin
            if (sd) begin
                p = pm[rg];
                nv[rg] = (vm[rg] & ~(32'hFF << (8 * p))) | ({24'h0, db} << (8 * p));
                np[rg] = (p + 1) % 4;
            end else begin
                nv[rg] = alu;
                np[rg] = 0;
            end
        end
        x.id = step_no; x.chk_rd = !r;
        x.sa = ns[ra]; x.sb = ns[rb]; x.va = nv[va]; x.vb = nv[vb];
        x.ptr = 2'(pm[rg]); x.commit = commit_m;
        q.push_back(x);
        @(posedge clk); #1;
        if (r) begin
            for (int i = 0; i < 16; i++) begin sm[i] = '0; vm[i] = '0; pm[i] = 0; end
            commit_m = 1'b0;
        end else begin
            sm = ns; vm = nv; pm = np;
            commit_m = we_s || we_v;
        end
        step_no++;
    endtask

    task automatic idle(input int rg, input int ra, input int rb, input int va, input int vb);
        step(0, 32'h0, 8'h0, 32'h0, rg, 0, 0, 0, 0, 0, ra, rb, va, vb);
    endtask

    task automatic pack(input int rg, input logic [7:0] db, input bit k);
        step(0, 32'h0, db, 32'h0, rg, 0, 1, 0, 1, k, 0, 0, rg, 0);
    endtask

    initial begin
        int rg;
        rst = 1'b1;
        bus.Do = '0; bus.Dob = '0; bus.ALU_Result = '0; bus.Rg = '0;
        bus.WE_C = 0; bus.WE_V = 0; bus.SEL_C = 0; bus.SEL_DAT = 0; bus.PROHIB_WB = 0;
        bus.rs_a = '0; bus.rs_b = '0; bus.rv_a = '0; bus.rv_b = '0;
        for (int i = 0; i < 16; i++) begin sm[i] = '0; vm[i] = '0; pm[i] = 0; end
        commit_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        step(1, 32'h0, 8'h0, 32'h12345678, 4, 1, 1, 0, 0, 0, 4, 0, 4, 0);
        idle(4, 4, 1, 4, 15);
        // Scalar ALU write with same-cycle bypass, then a dropped write to r0.
        step(0, 32'h0, 8'h0, 32'hDEADBEEF, 5, 1, 0, 0, 0, 0, 5, 0, 0, 0);
        idle(5, 5, 0, 5, 0);
        step(0, 32'h0, 8'h0, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0, 0, 5, 0, 0);
        idle(0, 0, 5, 0, 0);
        // Byte and word loads into r3.
        step(0, 32'hFFFFFFFF, 8'hA5, 32'h0, 3, 1, 0, 1, 1, 0, 3, 5, 0, 0);
        idle(3, 3, 0, 0, 0);
        step(0, 32'hFFFFFFFF, 8'hA5, 32'h0, 3, 1, 0, 0, 1, 0, 3, 0, 0, 0);
        idle(3, 3, 5, 0, 0);
        // Four-lane pack with wrap.
        pack(2, 8'h11, 0); pack(2, 8'h22, 0); pack(2, 8'h33, 0); pack(2, 8'h44, 0);
        idle(2, 0, 0, 2, 2);
        pack(2, 8'h55, 0);
        idle(2, 0, 0, 2, 0);
        // Kill mid-pack, word realign, reset mid-pack.
        pack(9, 8'hAA, 0); pack(9, 8'hBB, 0);
        pack(9, 8'hCC, 1);
        idle(9, 0, 0, 9, 2);
        step(0, 32'h0, 8'h0, 32'h01020304, 9, 0, 1, 0, 0, 0, 0, 0, 9, 0);
        idle(9, 0, 0, 9, 0);
        pack(9, 8'h77, 0);
        step(1, 32'h0, 8'h0, 32'h0, 9, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        idle(9, 5, 3, 9, 2);
        // Dual write to both files.
        idle(6, 0, 0, 0, 0);
        step(0, 32'h0, 8'h0, 32'hCAFEF00D, 6, 1, 0, 0, 0, 0, 6, 0, 0, 0);
        step(0, 32'h0, 8'h0, 32'hCAFEF00D, 7, 1, 1, 0, 0, 0, 7, 6, 7, 6);
        idle(7, 7, 8, 7, 8);

        for (int n = 0; n < 800; n++) begin
            rg = $urandom_range(0, 15);
            step(($urandom_range(0, 99) == 0), $urandom, 8'($urandom), $urandom, rg,
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1) ? rg : $urandom_range(0, 15),
                 $urandom_range(0, 15),
                 $urandom_range(0, 1) ? rg : $urandom_range(0, 15),
                 $urandom_range(0, 15));
        end

        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback stage directly downstream of the MEM/WB pipeline register. Selects the writeback value and commits it to a 16x32 scalar register file and a 16x32 vector register file. Each vector register holds four 8-bit lanes, and pixel bytes can be packed into it one lane per write. Provides bypassed read ports to the decode stage.

Parameters:
NUM_REGS, 16, number of scalar and number of vector registers (index width 4)
DATA_W, 32, register and word width
LANE_W, 8, vector lane and byte width (DATA_W/LANE_W = 4 lanes)

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  synchronous active-high reset
Do  in  32  memory load word from MEM/WB
Dob  in  8  memory load byte from MEM/WB
ALU_Result  in  32  ALU result from MEM/WB
Rg  in  4  destination register index
WE_C  in  1  scalar register write enable
WE_V  in  1  vector register write enable
SEL_C  in  1  scalar source width: 0 = Do word, 1 = Dob zero-extended
SEL_DAT  in  1  source select: 1 = memory data, 0 = ALU_Result
PROHIB_WB  in  1  writeback kill (squashed instruction)
rs_a, rs_b  in  4 each  scalar read indices
rv_a, rv_b  in  4 each  vector read indices
rd_sa, rd_sb  out  32 each  scalar read data
rd_va, rd_vb  out  32 each  vector read data
wb_commit  out  1  registered: a write committed last cycle
lane_ptr_dbg  out  2  lane pointer of vector register Rg (combinational)

Behaviour:
- Reset (rst=1 at a clock edge): clear all 32 registers, all 16 lane pointers and wb_commit to 0. Reset overrides any write in the same cycle. Mid-packing reset discards partial vectors.
- Effective enables: wec = WE_C & ~PROHIB_WB, wev = WE_V & ~PROHIB_WB. When PROHIB_WB=1, no state changes, including lane pointers.
- Scalar value:
  - SEL_DAT=0: ALU_Result.
  - SEL_DAT=1, SEL_C=0: Do.
  - SEL_DAT=1, SEL_C=1: {24'b0, Dob}.
- Scalar write: on the edge with wec=1, S[Rg] <= scalar value. S0 is hardwired to zero; writes to it are dropped and reads return 0.
- Vector write, wev=1:
  - SEL_DAT=1 (byte pack): lane L = ptr[Rg]. V[Rg][L*8+7:L*8] <= Dob; other lanes are held. ptr[Rg] <= L+1 mod 4, wrapping 3 to 0.
  - SEL_DAT=0 (word write): V[Rg] <= ALU_Result; ptr[Rg] <= 0.
  - SEL_C is ignored for vector writes.
- Simultaneous wec and wev: both commit, one to each file, same Rg.
- Reads are combinational with write-through bypass. If a read index matches Rg and the matching effective enable is set, the port returns the post-write value. For a byte pack this is the merged word. The scalar bypass is suppressed for index 0.
- wb_commit <= wec | wev, so it is 1 the cycle after any committed write. Reset value 0.
- Write latency is 1 edge; architectural read latency is 0 thanks to the bypass.

Decomposition:
- Shared package: DATA_W, LANE_W, NUM_REGS, REG_IDX_W=4, LANES=DATA_W/LANE_W, and SEL_DAT encodings SRC_ALU=0, SRC_MEM=1.
- One natural sub-module, vec_lane_packer: per-register lane pointers plus the byte-merge datapath, producing the merged word and next pointer for index Rg.
- Scalar file, muxing and bypass stay in the top.

Test Plan:
1. Reset, then read all ports -> every read port returns 0 and wb_commit=0. WE_C=1 with rst=1 -> no write.
2. Scalar ALU write: Rg=5, ALU_Result=0xDEADBEEF, SEL_DAT=0, WE_C=1.
   - Same cycle, rs_a=5 -> 0xDEADBEEF via bypass.
   - Next cycle -> still 0xDEADBEEF, wb_commit=1.
   - Rg=0 write -> rs_a=0 reads 0.
3. Scalar byte load: Rg=3, SEL_DAT=1, SEL_C=1, Dob=0xA5, Do=0xFFFFFFFF -> S3=0x000000A5. Repeat with SEL_C=0 -> S3=0xFFFFFFFF.
4. Vector pack: Rg=2, SEL_DAT=1, WE_V=1, Dob=0x11, 0x22, 0x33, 0x44 on consecutive cycles.
   - After the fourth write: V2=0x44332211, ptr wraps to 0.
   - A fifth byte 0x55 -> V2=0x44332255.
5. Kill and reset mid-pack:
   - After two bytes, PROHIB_WB=1 with WE_V=1 -> V and ptr unchanged (lane_ptr_dbg=2).
   - Word write ALU_Result=0x01020304 -> V=0x01020304, ptr=0.
   - Rst after one byte -> V=0, ptr=0.
6. Dual write: Rg=7, WE_C=WE_V=1, SEL_DAT=0, ALU_Result=0xCAFEF00D -> S7 and V7 both 0xCAFEF00D; other registers unchanged.
